// File: rtl/ictlb_fwd_arb.sv
// Instruction-side L1 TLB forward-port arbiter: shares one port between core
// fetches and prefetches (core priority, starvation guard) through a 2-entry queue.

package ictlb_fwd_pkg;
  typedef struct packed {
    logic [5:0]  coreid;
    logic [38:0] laddr;
  } I_coretoictlb_pc_type;

  typedef struct packed {
    logic        l2;
    logic [38:0] laddr;
  } I_pfetol1tlb_req_type;

  typedef struct packed {
    logic [5:0]  coreid;
    logic        prefetch;
    logic        l2_prefetch;
    logic [2:0]  fault;
    logic [10:0] hpaddr;
    logic [2:0]  ppaddr;
  } I_l1tlbtol1_fwd_type;
endpackage

module ictlb_fwd_arb
  import ictlb_fwd_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coretoictlb_pc_valid,
  output logic                 coretoictlb_pc_retry,
  input  I_coretoictlb_pc_type coretoictlb_pc,
  input  logic                 pfetol1tlb_req_valid,
  output logic                 pfetol1tlb_req_retry,
  input  I_pfetol1tlb_req_type pfetol1tlb_req,
  output logic                 l1tlbtol1_fwd_valid,
  input  logic                 l1tlbtol1_fwd_retry,
  output I_l1tlbtol1_fwd_type  l1tlbtol1_fwd
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e                occ;
  logic [CW-1:0]       starve_cnt;
  I_l1tlbtol1_fwd_type mem [2];
  logic                rd_ptr;
  logic                wr_ptr;

  logic                pf_l1;
  logic                pf_l2;
  logic                space;
  logic                starve_hit;
  logic                starve_win;
  logic                core_grant;
  logic                pf_grant;
  logic                enq;
  logic                deq;
  I_l1tlbtol1_fwd_type enq_data;

  // Only laddr[22:12] is meaningful in passthrough mode; the rest is ignored.
  logic unused_laddr;
  assign unused_laddr = ^{coretoictlb_pc.laddr[38:23], coretoictlb_pc.laddr[11:0],
                          pfetol1tlb_req.laddr[38:23], pfetol1tlb_req.laddr[11:0]};

  // Admission looks only at registered occupancy, so fwd_retry never reaches
  // the upstream retries combinationally.
  always_comb begin
    pf_l1      = pfetol1tlb_req_valid & ~pfetol1tlb_req.l2;
    pf_l2      = pfetol1tlb_req_valid & pfetol1tlb_req.l2;
    space      = (occ != FULL);
    starve_hit = (starve_cnt == CW'(STARVE_MAX));
    starve_win = reset & space & pf_l1 & starve_hit;
    core_grant = reset & ~starve_win & space & coretoictlb_pc_valid;
    pf_grant   = starve_win | (reset & ~core_grant & (occ == EMPTY) & pf_l1);
    enq        = core_grant | pf_grant;
    deq        = l1tlbtol1_fwd_valid & ~l1tlbtol1_fwd_retry;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    enq_data        = '0;
    enq_data.fault  = 3'b000;
    if (pf_grant) begin
      enq_data.coreid      = '0;
      enq_data.prefetch    = 1'b1;
      enq_data.l2_prefetch = 1'b1;
      enq_data.hpaddr      = pfetol1tlb_req.laddr[22:12];
      enq_data.ppaddr      = pfetol1tlb_req.laddr[14:12];
    end else begin
      enq_data.coreid      = coretoictlb_pc.coreid;
      enq_data.hpaddr      = coretoictlb_pc.laddr[22:12];
      enq_data.ppaddr      = coretoictlb_pc.laddr[14:12];
    end
  end

  assign coretoictlb_pc_retry = reset & coretoictlb_pc_valid & ~core_grant;
  assign pfetol1tlb_req_retry = reset & pfetol1tlb_req_valid & ~(pf_l2 | pf_grant);
  assign l1tlbtol1_fwd_valid  = (occ != EMPTY);
  assign l1tlbtol1_fwd        = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ        <= EMPTY;
      starve_cnt <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      // NOTE: queue storage is reset so the head payload reads 0 during reset.
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end

      if (enq && !deq) begin
        occ <= (occ == EMPTY) ? ONE : FULL;
      end else if (!enq && deq) begin
        occ <= (occ == FULL) ? ONE : EMPTY;
      end

      if (!pf_l1 || pf_grant) begin
        starve_cnt <= '0;
      end else if (core_grant && !starve_hit) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ictlb_fwd_arb.sv
// Directed, table-driven bench for ictlb_fwd_arb: per-cycle retry/forward
// expectations plus hand-written starvation and asynchronous reset sequences.

module tb_ictlb_fwd_arb;
  import ictlb_fwd_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 core_valid;
  logic                 core_retry;
  I_coretoictlb_pc_type core_pc;
  logic                 pf_valid;
  logic                 pf_retry;
  I_pfetol1tlb_req_type pf_req;
  logic                 fwd_valid;
  logic                 fwd_retry;
  I_l1tlbtol1_fwd_type  fwd;

  int total = 0;
  int bad   = 0;

  ictlb_fwd_arb #(.STARVE_MAX(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .coretoictlb_pc_valid (core_valid),
    .coretoictlb_pc_retry (core_retry),
    .coretoictlb_pc       (core_pc),
    .pfetol1tlb_req_valid (pf_valid),
    .pfetol1tlb_req_retry (pf_retry),
    .pfetol1tlb_req       (pf_req),
    .l1tlbtol1_fwd_valid  (fwd_valid),
    .l1tlbtol1_fwd_retry  (fwd_retry),
    .l1tlbtol1_fwd        (fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                cv;
    logic [5:0]          cid;
    logic [38:0]         claddr;
    logic                pv;
    logic                pl2;
    logic [38:0]         pladdr;
    logic                fret;
    logic                ecr;
    logic                epr;
    logic                efv;
    I_l1tlbtol1_fwd_type epay;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic I_l1tlbtol1_fwd_type exp_core(input logic [5:0] id, input logic [38:0] la);
    I_l1tlbtol1_fwd_type p;
    p.coreid      = id;
    p.prefetch    = 1'b0;
    p.l2_prefetch = 1'b0;
    p.fault       = 3'b000;
    p.hpaddr      = la[22:12];
    p.ppaddr      = la[14:12];
    return p;
  endfunction

  function automatic I_l1tlbtol1_fwd_type exp_pf(input logic [38:0] la);
    I_l1tlbtol1_fwd_type p;
    p.coreid      = 6'd0;
    p.prefetch    = 1'b1;
    p.l2_prefetch = 1'b1;
    p.fault       = 3'b000;
    p.hpaddr      = la[22:12];
    p.ppaddr      = la[14:12];
    return p;
  endfunction

  function automatic vec_t mk(input logic cv, input logic [5:0] cid, input logic [38:0] claddr,
                              input logic pv, input logic pl2, input logic [38:0] pladdr,
                              input logic fret, input logic ecr, input logic epr,
                              input logic efv, input I_l1tlbtol1_fwd_type epay);
    vec_t v;
    v.cv = cv; v.cid = cid; v.claddr = claddr;
    v.pv = pv; v.pl2 = pl2; v.pladdr = pladdr;
    v.fret = fret; v.ecr = ecr; v.epr = epr; v.efv = efv; v.epay = epay;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [5:0] cid, input logic [38:0] claddr,
                       input logic pv, input logic pl2, input logic [38:0] pladdr,
                       input logic fret);
    core_valid     = cv;
    core_pc.coreid = cid;
    core_pc.laddr  = claddr;
    pf_valid       = pv;
    pf_req.l2      = pl2;
    pf_req.laddr   = pladdr;
    fwd_retry      = fret;
  endtask

  task automatic drive_idle(input logic fret);
    drive(1'b0, 6'd0, 39'd0, 1'b0, 1'b0, 39'd0, fret);
  endtask

  task automatic check_fwd(input string name, input logic efv, input I_l1tlbtol1_fwd_type epay);
    check({name, "_fv"}, 32'(fwd_valid), 32'(efv));
    if (efv) check({name, "_pay"}, 32'(fwd), 32'(epay));
  endtask

  I_l1tlbtol1_fwd_type nopay;
  I_l1tlbtol1_fwd_type pa, pb, pc, pd, pp, pe, pf, ph, pq;
  logic [38:0] la_a, la_b, la_c, la_d, la_p, la_e, la_f, la_g, la_l2, la_h, la_q, la_r;

  initial begin
    nopay = '0;
    la_a = 39'h00_0045_6000; la_b = 39'h00_0011_1000; la_c = 39'h00_0022_2000;
    la_d = 39'h00_0033_3000; la_p = 39'h00_0055_5000; la_e = 39'h00_0066_6000;
    la_f = 39'h00_0077_7000; la_g = 39'h00_0088_8000; la_l2 = 39'h00_0099_9000;
    la_h = 39'h00_00AB_C000; la_q = 39'h00_00CD_E000; la_r = 39'h00_00F0_F000;

    pa = exp_core(6'd1, la_a);
    pb = exp_core(6'd2, la_b);
    pc = exp_core(6'd3, la_c);
    pd = exp_core(6'd4, la_d);
    pp = exp_pf(la_p);
    pe = exp_core(6'd6, la_e);
    pf = exp_core(6'd7, la_f);
    ph = exp_core(6'd9, la_h);
    pq = exp_pf(la_q);

    //              cv  cid   claddr pv   l2   pladdr fret  ecr  epr  efv  payload
    vecs[0]  = mk(1, 6'd1, la_a, 0, 0, 0,    0,   0, 0, 0, nopay);
    vecs[1]  = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 1, pa);
    vecs[2]  = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 0, nopay);
    vecs[3]  = mk(1, 6'd2, la_b, 0, 0, 0,    1,   0, 0, 0, nopay);
    vecs[4]  = mk(1, 6'd3, la_c, 0, 0, 0,    1,   0, 0, 1, pb);
    vecs[5]  = mk(1, 6'd4, la_d, 0, 0, 0,    1,   1, 0, 1, pb);
    vecs[6]  = mk(1, 6'd4, la_d, 0, 0, 0,    1,   1, 0, 1, pb);
    vecs[7]  = mk(1, 6'd4, la_d, 0, 0, 0,    0,   1, 0, 1, pb);
    vecs[8]  = mk(1, 6'd4, la_d, 0, 0, 0,    0,   0, 0, 1, pc);
    vecs[9]  = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 1, pd);
    vecs[10] = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 0, nopay);
    vecs[11] = mk(1, 6'd5, la_d, 0, 0, 0,    1,   0, 0, 0, nopay);
    vecs[12] = mk(0, 6'd0, 0,    1, 0, la_p, 1,   0, 1, 1, exp_core(6'd5, la_d));
    vecs[13] = mk(0, 6'd0, 0,    1, 0, la_p, 0,   0, 1, 1, exp_core(6'd5, la_d));
    vecs[14] = mk(0, 6'd0, 0,    1, 0, la_p, 0,   0, 0, 0, nopay);
    vecs[15] = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 1, pp);
    vecs[16] = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 0, nopay);
    vecs[17] = mk(1, 6'd6, la_e, 0, 0, 0,    1,   0, 0, 0, nopay);
    vecs[18] = mk(1, 6'd7, la_f, 0, 0, 0,    1,   0, 0, 1, pe);
    vecs[19] = mk(1, 6'd8, la_g, 1, 1, la_l2, 1,  1, 0, 1, pe);
    vecs[20] = mk(0, 6'd0, 0,    1, 1, la_l2, 1,  0, 0, 1, pe);
    vecs[21] = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 1, pe);
    vecs[22] = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 1, pf);
    vecs[23] = mk(0, 6'd0, 0,    0, 0, 0,    0,   0, 0, 0, nopay);

    // Reset phase with requests pending: nothing is granted or retried.
    reset = 1'b0;
    drive(1'b1, 6'd1, la_a, 1'b1, 1'b0, la_p, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst%0d_cr", i), 32'(core_retry), 32'd0);
      check($sformatf("rst%0d_pr", i), 32'(pf_retry), 32'd0);
      check($sformatf("rst%0d_fv", i), 32'(fwd_valid), 32'd0);
      check($sformatf("rst%0d_pay", i), 32'(fwd), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_idle(1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].cv, vecs[i].cid, vecs[i].claddr, vecs[i].pv, vecs[i].pl2,
            vecs[i].pladdr, vecs[i].fret);
      #1;
      check($sformatf("v%0d_cr", i), 32'(core_retry), 32'(vecs[i].ecr));
      check($sformatf("v%0d_pr", i), 32'(pf_retry), 32'(vecs[i].epr));
      check_fwd($sformatf("v%0d", i), vecs[i].efv, vecs[i].epay);
    end

    // Starvation guard: core wins 8 cycles, prefetch wins the 9th, core resumes.
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drive(1'b1, 6'd9, la_h, 1'b1, 1'b0, la_q, 1'b0);
      #1;
      check($sformatf("stv%0d_cr", k), 32'(core_retry), 32'(k == 9));
      check($sformatf("stv%0d_pr", k), 32'(pf_retry), 32'(k != 9));
      if (k == 1)       check_fwd($sformatf("stv%0d", k), 1'b0, nopay);
      else if (k == 10) check_fwd($sformatf("stv%0d", k), 1'b1, pq);
      else              check_fwd($sformatf("stv%0d", k), 1'b1, ph);
    end
    @(negedge clk);
    drive_idle(1'b0);
    #1;
    check_fwd("stv11", 1'b1, ph);
    @(negedge clk);
    #1;
    check_fwd("stv12", 1'b0, nopay);

    // Asynchronous reset with two entries queued.
    @(negedge clk);
    drive(1'b1, 6'd2, la_b, 1'b0, 1'b0, 39'd0, 1'b1);
    @(negedge clk);
    drive(1'b1, 6'd3, la_c, 1'b0, 1'b0, 39'd0, 1'b1);
    @(negedge clk);
    drive_idle(1'b1);
    #1;
    check_fwd("ar_full", 1'b1, pb);
    #2;
    reset = 1'b0;
    #1;
    check("ar_fv", 32'(fwd_valid), 32'd0);
    check("ar_pay", 32'(fwd), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive_idle(1'b0);
    @(negedge clk);
    drive(1'b1, 6'd10, la_r, 1'b0, 1'b0, 39'd0, 1'b0);
    #1;
    check("ar_new_cr", 32'(core_retry), 32'd0);
    check_fwd("ar_new0", 1'b0, nopay);
    @(negedge clk);
    drive_idle(1'b0);
    #1;
    check_fwd("ar_new1", 1'b1, exp_core(6'd10, la_r));
    @(negedge clk);
    #1;
    check_fwd("ar_new2", 1'b0, nopay);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ictlb_fwd_arb.md
# ictlb_fwd_arb

Sequencer and arbiter for the instruction-side L1 TLB forward port (`l1tlbtol1_fwd`). It shares that single port between core PC fetch requests and L1 prefetch requests. Core requests have priority. Prefetches use the port opportunistically, and a bounded starvation guard ensures they still make progress. A 2-entry output queue decouples the L1 retry path from the requesters. The block sits inside the ictlb, between the core/prefetch inputs and the L1 cache forward interface, in translation-passthrough mode (physical = linear address).

## Interface
- `STARVE_MAX`, default 8: number of consecutive lost cycles after which a pending L1 prefetch wins over the core.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `coretoictlb_pc_valid`  in  1  core fetch request valid.
- `coretoictlb_pc_retry`  out  1  core request not accepted this cycle.
- `coretoictlb_pc`  in  `I_coretoictlb_pc_type`  uses `coreid` and `laddr`.
- `pfetol1tlb_req_valid`  in  1  prefetch request valid.
- `pfetol1tlb_req_retry`  out  1  prefetch request not accepted this cycle.
- `pfetol1tlb_req`  in  `I_pfetol1tlb_req_type`  uses `l2` and `laddr`.
- `l1tlbtol1_fwd_valid`  out  1  queue head valid.
- `l1tlbtol1_fwd_retry`  in  1  L1 refuses the head this cycle.
- `l1tlbtol1_fwd`  out  `I_l1tlbtol1_fwd_type`  queue head payload.

## Operation
- **Handshake.** Valid/retry on every port. A transfer occurs when valid=1 and retry=0. A requester holds valid and payload stable while retried.
- **Retry outputs.** `*_retry = valid & ~grant`. Retry is 0 whenever the matching valid is 0.
- **Occupancy.** `occ` is a registered count in {0,1,2}; states EMPTY, ONE, FULL. The admission decision uses only the registered `occ`. There is no combinational path from `l1tlbtol1_fwd_retry` to either upstream retry.
- **Space rule.** `space = (occ != 2)`. A dequeue in the same cycle does not free a slot for an enqueue in that cycle.
- **Grant priority**, evaluated in order:
  1. Prefetch with `l2=1` is always accepted and discarded, with no enqueue. This is independent of `space` and of the core.
  2. If `space` and an L1 prefetch is valid (`l2=0`) and `starve_cnt == STARVE_MAX`: grant the prefetch and retry the core.
  3. Else if `space` and the core is valid: grant the core.
  4. Else if `occ == 0` and an L1 prefetch is valid: grant the prefetch. When the core is idle, prefetches only enter an empty queue.
- **Starvation counter.** `starve_cnt` is `$clog2(STARVE_MAX+1)` bits and saturates at `STARVE_MAX`.
  - Increments when an L1 prefetch is valid and the core was granted that cycle.
  - Holds when an L1 prefetch is valid but nothing was granted (`occ` FULL).
  - Clears when the prefetch is granted or when no L1 prefetch is valid.
- **Core payload:** `coreid = pc.coreid`, `prefetch = 0`, `l2_prefetch = 0`, `fault = 3'b000`, `hpaddr = laddr[22:12]`, `ppaddr = laddr[14:12]`.
- **Prefetch payload:** `coreid = 0`, `prefetch = 1`, `l2_prefetch = 1`, `fault = 3'b000`, with `hpaddr`/`ppaddr` taken as for the core.
- **Queue.** FIFO, at most one enqueue and one dequeue per cycle. Entries leave in grant order. The head is dequeued when `fwd_valid & ~fwd_retry`.
- **Occupancy update.** `occ` changes by (enqueue − dequeue). Simultaneous enqueue and dequeue at ONE stays ONE. Dequeue in FULL goes to ONE.

## Timing
- **Reset.** While `reset=0`:
  - `occ = 0`, `starve_cnt = 0`, `l1tlbtol1_fwd_valid = 0`, `l1tlbtol1_fwd` payload = 0.
  - Both upstream retries = 0; no grants occur.
  - Reset mid-operation discards all queued entries immediately (asynchronous).
- **Latency.** A request granted in cycle N appears on `l1tlbtol1_fwd` in N+1 when the queue was empty. Otherwise it appears after the entries ahead of it drain.
- **Throughput.** One forward per cycle when `fwd_retry=0`.
- **Output stability.** While `fwd_retry=1`, `l1tlbtol1_fwd_valid` and `l1tlbtol1_fwd` hold stable.
- **Full queue.** While FULL, every request except `l2=1` prefetches is retried, including in cycles where the head dequeues.

## Test plan
- **Reset and single core request.** Hold `reset=0` for 3 cycles, then release; assert core valid with `laddr=0x0045_6000`, `coreid=1` for one cycle.
  - During reset: all outputs 0.
  - Next cycle: `fwd_valid=1`, `hpaddr=0x456`, `ppaddr=3'b110`, `prefetch=0`, `fault=0`.
- **Backpressure fill.** Hold `fwd_retry=1`; send 3 back-to-back core requests.
  - First two accepted; third sees `pc_retry=1` until `fwd_retry` drops.
  - All three appear on `fwd` in order with no loss or duplicate.
- **Opportunistic prefetch.** Core idle; L1 prefetch (`l2=0`) valid while `occ=1`.
  - `pfe_retry=1`; it is granted the first cycle `occ=0`.
  - Output shows `prefetch=1`, `coreid=0`.
- **Starvation guard.** Core valid every cycle with `fwd_retry=0`; L1 prefetch valid continuously; `STARVE_MAX=8`.
  - Core is granted 8 cycles.
  - Cycle 9: prefetch granted and `pc_retry=1`; counter clears; the core wins again from cycle 10.
- **L2 prefetch drop.** `l2=1` prefetch valid while FULL and core valid.
  - `pfe_retry=0` and no entry enqueued.
  - Core still retried.
- **Async reset with 2 entries queued.** Assert `reset=0` mid-cycle.
  - `fwd_valid` goes to 0 immediately.
  - After release: queue empty, first new request is forwarded one cycle after its grant.
